// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared constants, FSM state type and element placement for the 5x5 matrix loader
package mat_pkg;

  localparam int MAT_N     = 5;
  localparam int MAT_W     = 17;
  localparam int MAT_ELEMS = 25;
  localparam int IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    DROP
  } state_t;

  // Bit offset of element (r,c) inside the flattened matrix word
  function automatic int elem_lsb(input int r, input int c);
    return (r * MAT_N + c) * MAT_W;
  endfunction

endpackage

// File: rtl/mat_bank.sv
// rtl/mat_bank.sv - 25-entry element register bank with indexed write and flattened read
module mat_bank
  import mat_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [IDX_W-1:0]           widx,
  input  logic [MAT_W-1:0]           wdata,
  output logic [MAT_ELEMS*MAT_W-1:0] rdata
);

  // Only the addressed slot loads; untouched slots keep the previous frame's value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (we) begin
      for (int r = 0; r < MAT_N; r++) begin
        for (int c = 0; c < MAT_N; c++) begin
          if (widx == IDX_W'(r * MAT_N + c)) begin
            rdata[elem_lsb(r, c) +: MAT_W] <= wdata;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mat_stream_loader.sv
// rtl/mat_stream_loader.sv - element stream to 5x5 matrix word loader; MAT_LOADER_DBUF_EN selects ping/pong banks
module mat_stream_loader
  import mat_pkg::*;
#(
  parameter int N = MAT_N,
  parameter int W = MAT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [W-1:0]       s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [N*N*W-1:0]   m_data,
  output logic [IDX_W-1:0]   m_count,
  output logic               err_len
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             s_rdy_q;
  logic             accept;
  logic             last_slot;
  logic             bank_we;

  // Reset must drop s_ready at once, so the registered flag is gated by rst_n
  assign s_ready   = rst_n & s_rdy_q;
  assign accept    = s_valid & s_ready;
  assign last_slot = (idx == IDX_W'(MAT_ELEMS - 1));
  assign m_count   = idx;

  // Write only elements that belong to a frame still considered good
  assign bank_we = accept &&
                   (((state == IDLE) && !s_last) ||
                    ((state == LOAD) && (s_last == last_slot)));

`ifdef MAT_LOADER_DBUF_EN

  logic             wr_sel;
  logic             rd_sel;
  logic [1:0]       full;
  logic [1:0]       full_nx;
  logic             rd_nx;
  logic             pop;
  logic             complete;
  logic [N*N*W-1:0] bank0_q;
  logic [N*N*W-1:0] bank1_q;

  assign pop      = m_valid & m_ready;
  assign complete = accept && (state == LOAD) && last_slot && s_last;
  assign rd_nx    = rd_sel ^ pop;
  assign m_data   = rd_sel ? bank1_q : bank0_q;

  // Bank occupancy after this edge: a pop frees the read bank, a completion fills the write bank
  always_comb begin
    full_nx = full;
    if (pop)      full_nx[rd_sel] = 1'b0;
    if (complete) full_nx[wr_sel] = 1'b1;
  end

  mat_bank u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we && !wr_sel),
    .widx  (idx),
    .wdata (s_data),
    .rdata (bank0_q)
  );

  mat_bank u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we && wr_sel),
    .widx  (idx),
    .wdata (s_data),
    .rdata (bank1_q)
  );

  // Frame-length FSM plus ping/pong bookkeeping; HOLD means both banks are occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      s_rdy_q <= 1'b1;
      m_valid <= 1'b0;
      err_len <= 1'b0;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      full    <= 2'b00;
    end else begin
      err_len <= 1'b0;
      full    <= full_nx;
      rd_sel  <= rd_nx;
      m_valid <= full_nx[rd_nx];
      case (state)
        IDLE: begin
          if (accept) begin
            if (s_last) begin
              err_len <= 1'b1;
              idx     <= '0;
            end else begin
              idx   <= IDX_W'(1);
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (last_slot) begin
              if (s_last) begin
                wr_sel <= ~wr_sel;
                if (full_nx[~wr_sel]) begin
                  state   <= HOLD;
                  idx     <= IDX_W'(MAT_ELEMS);
                  s_rdy_q <= 1'b0;
                end else begin
                  state <= IDLE;
                  idx   <= '0;
                end
              end else begin
                err_len <= 1'b1;
                idx     <= '0;
                state   <= DROP;
              end
            end else if (s_last) begin
              err_len <= 1'b1;
              idx     <= '0;
              state   <= IDLE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DROP: begin
          if (accept && s_last) begin
            state <= IDLE;
            idx   <= '0;
          end
        end
        HOLD: begin
          if (pop) begin
            state   <= IDLE;
            idx     <= '0;
            s_rdy_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  mat_bank u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we),
    .widx  (idx),
    .wdata (s_data),
    .rdata (m_data)
  );

  // Frame-length FSM; HOLD presents the single bank until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      s_rdy_q <= 1'b1;
      m_valid <= 1'b0;
      err_len <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (s_last) begin
              err_len <= 1'b1;
              idx     <= '0;
            end else begin
              idx   <= IDX_W'(1);
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (last_slot) begin
              if (s_last) begin
                state   <= HOLD;
                idx     <= IDX_W'(MAT_ELEMS);
                s_rdy_q <= 1'b0;
                m_valid <= 1'b1;
              end else begin
                err_len <= 1'b1;
                idx     <= '0;
                state   <= DROP;
              end
            end else if (s_last) begin
              err_len <= 1'b1;
              idx     <= '0;
              state   <= IDLE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DROP: begin
          if (accept && s_last) begin
            state <= IDLE;
            idx   <= '0;
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
            idx     <= '0;
            s_rdy_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_mat_stream_loader.sv
// tb/tb_mat_stream_loader.sv - directed self-checking bench for mat_stream_loader (single bank, or MAT_LOADER_DBUF_EN)
module tb_mat_stream_loader;

  localparam int DW = 425;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          m_ready = 1'b0;
  logic [16:0]   s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic          err_len;
  logic [DW-1:0] m_data;
  logic [4:0]    m_count;
  logic [DW-1:0] held;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] pat [25] = '{17'd1, 17'd2, 17'd2, 17'd1, 17'd2,
                            17'd2, 17'd1, 17'd1, 17'd2, 17'd1,
                            17'd1, 17'd2, 17'd1, 17'd2, 17'd1,
                            17'd2, 17'd1, 17'd2, 17'd2, 17'd1,
                            17'd1, 17'd1, 17'd1, 17'd2, 17'd1};

  mat_stream_loader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count),
    .err_len (err_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Base 0 selects the nominal pattern; otherwise element i carries base+i
  function automatic logic [16:0] fval(input int base, input int i);
    if (base == 0) return pat[i];
    return 17'(base + i);
  endfunction

  function automatic logic [DW-1:0] frame_exp(input int base);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < 25; i++) v[i*17 +: 17] = fval(base, i);
    return v;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting rising edge
  task automatic push(input logic [16:0] d, input logic l);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", DW'(s_ready), DW'(1));
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push_frame(input int base, input int n, input int last_at);
    for (int i = 0; i < n; i++) push(fval(base, i), (i == last_at));
  endtask

  initial begin
    @(negedge clk);
    check("rst_m_valid", DW'(m_valid), DW'(0));
    check("rst_s_ready", DW'(s_ready), DW'(0));
    check("rst_m_count", DW'(m_count), DW'(0));
    check("rst_err_len", DW'(err_len), DW'(0));
    check("rst_m_data",  m_data, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", DW'(s_ready), DW'(1));

`ifdef MAT_LOADER_DBUF_EN
    push_frame(0, 25, 24);
    check("db_f1_valid",  DW'(m_valid), DW'(1));
    check("db_f1_ready",  DW'(s_ready), DW'(1));
    check("db_f1_data",   m_data, frame_exp(0));
    push_frame(100, 24, -1);
    check("db_49_ready",  DW'(s_ready), DW'(1));
    check("db_49_data",   m_data, frame_exp(0));
    push(fval(100, 24), 1'b1);
    check("db_50_ready",  DW'(s_ready), DW'(0));
    check("db_50_count",  DW'(m_count), DW'(25));
    check("db_50_data",   m_data, frame_exp(0));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("db_f2_valid",  DW'(m_valid), DW'(1));
    check("db_f2_data",   m_data, frame_exp(100));
    check("db_f2_ready",  DW'(s_ready), DW'(1));
    push_frame(300, 5, -1);
    m_ready = 1'b1;
    check("db_hs_ready",  DW'(s_ready), DW'(1));
    push(fval(300, 5), 1'b0);
    m_ready = 1'b0;
    check("db_hs_valid",  DW'(m_valid), DW'(0));
    check("db_hs_count",  DW'(m_count), DW'(6));
`else
    // Nominal frame
    push_frame(0, 24, -1);
    check("nom_24_valid", DW'(m_valid), DW'(0));
    check("nom_24_count", DW'(m_count), DW'(24));
    push(fval(0, 24), 1'b1);
    check("nom_valid",    DW'(m_valid), DW'(1));
    check("nom_e11",      DW'(m_data[16:0]), DW'(1));
    check("nom_e12",      DW'(m_data[33:17]), DW'(2));
    check("nom_e55",      DW'(m_data[424:408]), DW'(1));
    check("nom_data",     m_data, frame_exp(0));
    check("nom_count",    DW'(m_count), DW'(25));
    check("nom_s_ready",  DW'(s_ready), DW'(0));

    // Consumer backpressure
    held = m_data;
    repeat (10) @(negedge clk);
    check("bp_valid",     DW'(m_valid), DW'(1));
    s_valid = 1'b1;
    s_data  = 17'd7;
    repeat (2) @(negedge clk);
    check("bp_data",      m_data, held);
    check("bp_count",     DW'(m_count), DW'(25));
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("hs_s_ready_0", DW'(s_ready), DW'(0));
    @(negedge clk);
    m_ready = 1'b0;
    check("hs_valid",     DW'(m_valid), DW'(0));
    check("hs_s_ready",   DW'(s_ready), DW'(1));
    check("hs_count",     DW'(m_count), DW'(0));

    // Early last on the 10th element
    push_frame(50, 10, 9);
    check("early_err",    DW'(err_len), DW'(1));
    check("early_count",  DW'(m_count), DW'(0));
    check("early_valid",  DW'(m_valid), DW'(0));
    @(negedge clk);
    check("early_err_1c", DW'(err_len), DW'(0));
    push_frame(100, 25, 24);
    check("early_f_valid", DW'(m_valid), DW'(1));
    check("early_f_data",  m_data, frame_exp(100));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;

    // Missing last, junk, then a good frame
    push_frame(150, 25, -1);
    check("miss_err",     DW'(err_len), DW'(1));
    check("miss_valid",   DW'(m_valid), DW'(0));
    check("miss_count",   DW'(m_count), DW'(0));
    push(17'd9, 1'b0);
    check("junk_err",     DW'(err_len), DW'(0));
    push(17'd9, 1'b0);
    push(17'd9, 1'b1);
    check("junk_valid",   DW'(m_valid), DW'(0));
    check("junk_count",   DW'(m_count), DW'(0));
    push_frame(200, 25, 24);
    check("miss_f_valid", DW'(m_valid), DW'(1));
    check("miss_f_data",  m_data, frame_exp(200));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
`endif

    // Reset mid-frame
    push_frame(250, 12, -1);
    check("mid_count",    DW'(m_count), DW'(12));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", DW'(m_valid), DW'(0));
    check("mid_rst_ready", DW'(s_ready), DW'(0));
    check("mid_rst_count", DW'(m_count), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while a matrix is held
    push_frame(300, 25, 24);
    check("hold_valid",   DW'(m_valid), DW'(1));
    rst_n = 1'b0;
    #1;
    check("hold_rst_valid", DW'(m_valid), DW'(0));
    check("hold_rst_ready", DW'(s_ready), DW'(0));
    check("hold_rst_data",  m_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh frame after reset starts at index 0
    push(fval(0, 0), 1'b0);
    check("fresh_count1", DW'(m_count), DW'(1));
    for (int i = 1; i < 25; i++) push(fval(0, i), (i == 24));
    check("fresh_valid",  DW'(m_valid), DW'(1));
    check("fresh_data",   m_data, frame_exp(0));
    check("fresh_count",  DW'(m_count), DW'(25));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_stream_loader.md
Name: mat_stream_loader

Overview:
- Upstream stage of the 5x5 matrix inverse datapath.
- Accepts matrix elements one at a time on a valid/ready stream, in row-major order, and collects them into a register bank.
- Presents the complete matrix as one flattened parallel word, with a valid/ready handshake, to the combinational inverse block (inputs i11..i55).
- Checks frame length against an end-of-matrix marker and resynchronises on error.

Parameters:
- N, 5, matrix dimension; the elaborated design fixes this at 5.
- W, 17, element width in bits; matches the inverse block's 17-bit element inputs.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  loader can accept an element.
- s_data  in  W  element value.
- s_last  in  1  marks the final (25th) element of a matrix.
- m_valid  out  1  complete matrix available on m_data.
- m_ready  in  1  consumer accepts the matrix.
- m_data  out  N*N*W (425)  element (r,c), 0-based, at bits [(r*N+c)*W +: W]; i11 = [16:0], i55 = [424:408].
- m_count  out  5  number of elements accepted into the current frame (0..25).
- err_len  out  1  one-cycle pulse on a frame-length error.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, idx=0.
  - m_valid=0, err_len=0, m_count=0, m_data=0.
  - s_ready is forced 0 while rst_n is low.
- Accept condition: s_valid && s_ready on a clk edge. s_data is written to bank[idx] and idx increments.
- State IDLE:
  - s_ready=1.
  - First accept moves to LOAD with idx=1.
  - An accept with s_last=1 here is a length error: pulse err_len, stay in IDLE, idx=0, data discarded.
- State LOAD:
  - s_ready=1.
  - Accept at idx<24 with s_last=1: early-last error. Pulse err_len, discard the frame, idx=0, go to IDLE.
  - Accept at idx==24 with s_last=1: go to HOLD. m_valid=1 from the next cycle.
  - Accept at idx==24 with s_last=0: missing-last error. Pulse err_len, discard the frame, go to DROP.
- State DROP:
  - s_ready=1; elements are accepted and discarded.
  - An accept with s_last=1 goes to IDLE, idx=0.
- State HOLD:
  - s_ready=0; m_valid=1.
  - m_data is stable until m_valid && m_ready.
  - On that handshake: m_valid=0 next cycle, state=IDLE, idx=0.
  - This gives one bubble cycle: s_ready rises the cycle after the handshake.
- Latency: m_valid rises 1 cycle after the 25th accept.
- m_count: equals idx; holds 25 in HOLD.
- err_len: registered, high for exactly one cycle per error event.
- m_data: changes only in IDLE/LOAD as elements are written.
  - Elements not yet rewritten keep their previous frame's values.
  - Consumers must qualify m_data with m_valid.
- Asserting m_ready while m_valid=0 has no effect.
- Reset mid-frame or mid-HOLD: partial or held matrix is lost, m_valid drops immediately (async).

Optional Feature:
- Macro MAT_LOADER_DBUF_EN.
- Defined: two banks (ping/pong).
  - Loading proceeds into the free bank while the other is held.
  - s_ready=0 only when both banks are full.
  - m_data is muxed from the oldest full bank; frames are delivered in arrival order.
  - Back-to-back matrices have no bubble: s_ready stays 1 through the m_ready handshake when one bank is free.
- Undefined: single bank exactly as described above, including the one-cycle bubble after each handshake.

Decomposition:
- Package mat_pkg:
  - constants MAT_N=5, MAT_W=17, MAT_ELEMS=25, IDX_W=5;
  - state typedef {IDLE, LOAD, HOLD, DROP};
  - function elem_lsb(r,c) returning (r*MAT_N+c)*MAT_W.
- Sub-module mat_bank: 25xW register bank with write-enable and 5-bit write index, flattened read port.
  - Instantiated once, or twice under MAT_LOADER_DBUF_EN.
  - The FSM and handshakes stay in mat_stream_loader.

Test Plan:
- Nominal frame: stream 1,2,2,1,2, 2,1,1,2,1, 1,2,1,2,1, 2,1,2,2,1, 1,1,1,2,1, with s_last on the 25th and m_ready=0.
  - Expect m_valid=1 one cycle after the 25th accept, m_data[16:0]=1, m_data[33:17]=2, m_data[424:408]=1, m_count=25, s_ready=0.
- Consumer backpressure: hold m_ready=0 for 10 cycles, then drive s_valid with data 7.
  - Expect m_data unchanged and no accept.
  - Then pulse m_ready: m_valid=0 next cycle, s_ready=1 the cycle after.
- Early last: s_last on the 10th element.
  - Expect one err_len pulse, m_count=0, m_valid never asserted.
  - A following good 25-element frame is delivered correctly.
- Missing last: 25 elements with no s_last, then 3 junk elements, the 3rd with s_last, then a good frame.
  - Expect err_len on the 25th element, junk dropped, the good frame delivered intact.
- Reset mid-operation: rst_n low after 12 elements, then in HOLD.
  - Expect m_valid=0 and s_ready=0 immediately, m_count=0.
  - After release, a fresh frame loads from index 0.
- Double buffer (macro defined): two frames streamed back to back with m_ready=0.
  - Expect s_ready=0 only after the 50th element.
  - Frame 1 is delivered first, then frame 2 on the next m_ready, with no bubble cycles.
